serial_to_parallel8: RTL
========================

// Module: serial_to_parallel8
// PURPOSE
//   Serial-in/parallel-out word capture: the inverse of the 8:1 select mux.
//   Bit k of the output word is filled from din on the k-th enabled cycle, steered by an
//   internal 3-bit index counter that plays the role of the mux select, read in reverse.
//   Sits at the receive end of a bit-serial link and hands complete words to downstream logic.
// PARAMETERS
//   WIDTH     8  word width in bits; must be >= 2 and equal 2**IDX_W
//   IDX_W     3  index counter width
//   LSB_FIRST 1  1: k-th bit lands in q[k]; 0: k-th bit lands in q[WIDTH-1-k]
// PORTS
//   clk    in   1      single clock; all state updates on posedge
//   rst_n  in   1      asynchronous, active-low reset
//   en     in   1      din is valid this cycle; 0 stalls capture
//   start  in   1      first-bit marker; (re)starts a word
//   din    in   1      serial data bit
//   q      out  WIDTH  last completed word; held until the next completion
//   valid  out  1      1-cycle pulse: q was updated on this edge
//   busy   out  1      1 while in CAPTURE
//   idx    out  IDX_W  index of the next bit to be written
//   abort  out  1      1-cycle pulse: partial word discarded by start
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; q=0, valid=0, busy=0, idx=0, abort=0; internal buffer=0.
//     Reset mid-word discards the partial word; q returns to 0.
//   - States: IDLE and CAPTURE. busy = (state==CAPTURE), registered.
//   - Priority: rst_n > start > en. valid and abort default to 0 each cycle.
//   - start=1, any state:
//       - partial buffer discarded.
//       - abort=1 if state==CAPTURE and at least one bit has been captured (idx!=0).
//       - If en=1: din is written to position 0 and idx<=1. If en=0: idx<=0.
//       - state<=CAPTURE.
//   - CAPTURE, start=0, en=1:
//       - din is written to position idx.
//       - If idx==WIDTH-1: q<=completed word (this bit included), valid=1, idx<=0, state<=IDLE.
//       - Otherwise idx<=idx+1.
//   - CAPTURE, en=0, start=0: hold; no state, idx or output change.
//   - IDLE, start=0: en and din are ignored; idx stays 0.
//   - Simultaneous start and last bit (idx==WIDTH-1): start wins.
//     No valid; abort=1; a new word begins per the start rule.
//   - Latency: valid and the new q appear on the same edge that samples the last bit.
//     Back-to-back words are allowed: start on the cycle after valid produces no bubble penalty.
//   - idx wraps only through completion or start; it never counts past WIDTH-1.
//   - Position mapping: position p maps to q[p] if LSB_FIRST=1, else q[WIDTH-1-p].
// TESTING
//   1 Reset: hold rst_n=0 -> q=0, valid=0, busy=0, idx=0, abort=0; release -> IDLE.
//     Pulse en with start=0 -> still idle.
//   2 Basic word: start+en with din=1,0,1,0,0,1,0,1 over 8 consecutive cycles ->
//     valid high for exactly 1 cycle after the 8th edge; q=8'hA5; busy low afterwards.
//   3 Stall: same 0xA5 stream with en=0 inserted after bits 2 and 5 (2 cycles each) ->
//     idx holds during gaps; q=8'hA5 after 12 cycles total; a single valid pulse.
//   4 Restart: 4 bits captured, then start+en with the 0x3C stream ->
//     abort=1 for 1 cycle; the following valid gives q=8'h3C; the partial word is never output.
//   5 Collisions:
//     - start asserted on the 8th-bit cycle -> no valid, abort=1, idx=1.
//     - rst_n low after bit 5 -> q=0, no valid.
//   6 Back-to-back and MSB-first:
//     - 0xA5 then 0x3C with no gap -> two valid pulses 8 cycles apart.
//     - LSB_FIRST=0 with the 0xA5 stream -> q=8'hA5 bit-reversed = 8'hA5.
//     - LSB_FIRST=0 with the 0x3C stream -> q=8'h3C reversed = 8'h3C;
//       then 0x01 stream -> q=8'h80.

Source files
------------

// File: rtl/serial_to_parallel8_if.sv
// Bundle of the serial receive signals: bit stream in, assembled word and status out.
// The bench drives through the master side; serial_to_parallel8 uses the slave side.
interface serial_to_parallel8_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic             en;
  logic             start;
  logic             din;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             busy;
  logic [IDX_W-1:0] idx;
  logic             abort;

  modport master (
    output en, start, din,
    input  q, valid, busy, idx, abort
  );

  modport slave (
    input  en, start, din,
    output q, valid, busy, idx, abort
  );
endinterface

// File: rtl/serial_to_parallel8.sv
// Serial-in/parallel-out word capture: bit k of a word comes from din on the k-th enabled
// cycle after start, and the finished word is presented on q with a one-cycle valid pulse.
module serial_to_parallel8 #(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = 3,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_to_parallel8_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] buf_r, buf_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             valid_r, valid_s;
  logic             abort_r, abort_s;
  logic             busy_r;

  // Bit position within q of the p-th captured bit.
  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] r;
    if (LSB_FIRST) begin
      r = p;
    end else begin
      r = LAST_IDX - p;
    end
    return r;
  endfunction

  // Next-state, capture buffer and pulse generation; start outranks en.
  always_comb begin
    state_s = state_r;
    buf_s   = buf_r;
    q_s     = q_r;
    idx_s   = idx_r;
    valid_s = 1'b0;
    abort_s = 1'b0;
    if (bus.start) begin
      // A restart throws away any partial word, even on what would have been its last bit.
      buf_s   = {WIDTH{1'b0}};
      abort_s = (state_r == CAPTURE) && (idx_r != ZERO_IDX);
      if (bus.en) begin
        buf_s[bit_pos(ZERO_IDX)] = bus.din;
        idx_s = ONE_IDX;
      end else begin
        idx_s = ZERO_IDX;
      end
      state_s = CAPTURE;
    end else begin
      case (state_r)
        CAPTURE: begin
          if (bus.en) begin
            buf_s[bit_pos(idx_r)] = bus.din;
            if (idx_r == LAST_IDX) begin
              q_s     = buf_s;
              valid_s = 1'b1;
              buf_s   = {WIDTH{1'b0}};
              idx_s   = ZERO_IDX;
              state_s = IDLE;
            end else begin
              idx_s = idx_r + ONE_IDX;
            end
          end else begin
            idx_s = idx_r;
          end
        end
        IDLE: begin
          idx_s = ZERO_IDX;
        end
        default: begin
          state_s = IDLE;
          idx_s   = ZERO_IDX;
          buf_s   = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State and output registers; reset clears everything including the completed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      buf_r   <= {WIDTH{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      idx_r   <= ZERO_IDX;
      valid_r <= 1'b0;
      abort_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      buf_r   <= buf_s;
      q_r     <= q_s;
      idx_r   <= idx_s;
      valid_r <= valid_s;
      abort_r <= abort_s;
      busy_r  <= (state_s == CAPTURE);
    end
  end

  assign bus.q     = q_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy_r;
  assign bus.idx   = idx_r;
  assign bus.abort = abort_r;

endmodule
